wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  - Write-back stage: MEM/WB pipeline register plus write-back datapath, directly downstream of the memory stage.
//  - Registers the memory-stage outputs and selects ALU result or load data.
//  - Drives the register-file write port and a forwarding tap.
//  - Keeps a retired-instruction counter.
// PARAMETERS
//  RET_CNT_W  64  width of retired-instruction counter
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  ms_valid       in   1   memory stage holds a valid instruction
//  ms_mem_out     in   32  raw word read from data RAM
//  ms_alu_result  in   32  ALU result / memory address
//  ms_rd          in   5   destination register
//  ms_ctrl        in   6   [5]=reg_write [4]=branch [3]=mem_read [2]=mem_write [1]=mem_to_reg [0]=alu_src
//  ms_funct3      in   3   load width/sign code (RV32I encoding)
//  wb_stall       in   1   hold WB register contents
//  wb_flush       in   1   kill instruction entering WB
//  rf_we          out  1   register-file write enable
//  rf_waddr       out  5   register-file write address
//  rf_wdata       out  32  register-file write data
//  wb_valid       out  1   WB register holds a valid instruction
//  wb_fwd_rd      out  5   forwarding tap: rd when rf_we=1, else 0
//  wb_fwd_data    out  32  forwarding tap: equals rf_wdata
//  wb_instret     out  RET_CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset (rst_n=0, async): wb_valid=0; all WB registers (rd, ctrl, alu, mem, funct3) =0; wb_instret=0.
//    Hence rf_we=0, rf_waddr=0, rf_wdata=0, wb_fwd_rd=0.
//  - Register update, each rising clk edge, priority order:
//    1. wb_flush=1: wb_valid<=0. Data registers load ms_* if wb_stall=0, otherwise hold. Flush wins over stall.
//    2. wb_stall=1: all WB registers hold, including wb_valid.
//    3. Otherwise: capture all ms_* inputs; wb_valid<=ms_valid.
//  - Latency: exactly 1 cycle from ms_* to rf_* outputs; outputs are combinational from WB registers.
//  - rf_we = wb_valid & ctrl[5] & (rd!=0). x0 is never written.
//  - rf_waddr = rd, driven regardless of rf_we.
//  - rf_wdata = ctrl[1] ? load_data : alu_result.
//  - During a stall, the held instruction keeps rf_we asserted; the repeated identical write is benign.
//  - wb_instret increments by 1 on each edge that takes branch 3 with ms_valid=1.
//    No increment on flush or stall; the counter wraps to 0 at all-ones.
//    A valid instruction with reg_write=0 (store, branch) still counts.
//  - Mid-operation reset: asserting rst_n=0 clears everything immediately, independent of clk. No partial state survives.
// CONFIGURATION
//  - Macro WB_LOAD_EXT_EN defined: load_data is built from funct3 and off=alu_result[1:0]:
//    000 LB   sign-extend byte at off
//    001 LH   sign-extend half at off[1] (off[0] ignored)
//    010 LW   full word (off ignored)
//    100 LBU  zero-extend byte
//    101 LHU  zero-extend half
//    011/110/111  full word
//    Little-endian: byte k = mem[8k+7:8k].
//  - Macro undefined: load_data = mem word unmodified; funct3 register and extension logic are removed.
// TESTING
//  - ALU write: ms_valid=1, ctrl=6'b100000, rd=5, alu=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, wb_instret=1.
//  - x0 guard: rd=0, reg_write=1, alu=0xFFFF -> rf_we=0, wb_fwd_rd=0; wb_instret still increments.
//  - Stall/flush: stall 3 cycles -> outputs frozen, instret unchanged.
//    stall+flush on the same edge -> wb_valid=0, rf_we=0, data regs held.
//  - Load ext (WB_LOAD_EXT_EN): mem=0x80FF7F01, mem_to_reg=1. Expected rf_wdata:
//    LB off=3 -> 0xFFFFFF80
//    LBU off=1 -> 0x0000007F
//    LH off=2 -> 0xFFFF80FF
//    LHU off=0 -> 0x00007F01
//    Macro undefined -> 0x80FF7F01 for all of the above.
//  - Async reset mid-stream: drop rst_n between clk edges while rf_we=1 -> rf_we=0 and wb_instret=0 before the next edge.
//  - Counter wrap: RET_CNT_W=4, 16 valid captures -> wb_instret returns to 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load-data select, register-file write port, forwarding tap, retired count.
// Define WB_LOAD_EXT_EN to build byte/half sign/zero extension of load data from funct3 and the address offset.
module wb_stage #(
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ms_valid,
  input  logic [31:0]          ms_mem_out,
  input  logic [31:0]          ms_alu_result,
  input  logic [4:0]           ms_rd,
  input  logic [5:0]           ms_ctrl,
  input  logic [2:0]           ms_funct3,
  input  logic                 wb_stall,
  input  logic                 wb_flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 wb_valid,
  output logic [4:0]           wb_fwd_rd,
  output logic [31:0]          wb_fwd_data,
  output logic [RET_CNT_W-1:0] wb_instret
);

  // Only reg_write and mem_to_reg are consumed at write-back.
  logic                 valid_q, valid_d;
  logic [4:0]           rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic [31:0]          alu_q, alu_d;
  logic [31:0]          mem_q, mem_d;
  logic [RET_CNT_W-1:0] instret_q, instret_d;
  logic [31:0]          load_data;
  logic                 capture;

  assign capture = ~wb_stall;

  always_comb begin
    valid_d      = valid_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    instret_d    = instret_q;
    if (capture) begin
      rd_d         = ms_rd;
      reg_write_d  = ms_ctrl[5];
      mem_to_reg_d = ms_ctrl[1];
      alu_d        = ms_alu_result;
      mem_d        = ms_mem_out;
    end
    // Flush kills the entering instruction even when stalled; data regs still follow the stall.
    if (wb_flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = ms_valid;
      if (ms_valid) instret_d = instret_q + {{(RET_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      mem_q        <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_q        <= alu_d;
      mem_q        <= mem_d;
      instret_q    <= instret_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign funct3_d = capture ? ms_funct3 : funct3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) funct3_q <= '0;
    else        funct3_q <= funct3_d;
  end

  always_comb begin
    ld_byte = mem_q[7:0];
    case (alu_q[1:0])
      2'd1:    ld_byte = mem_q[15:8];
      2'd2:    ld_byte = mem_q[23:16];
      2'd3:    ld_byte = mem_q[31:24];
      default: ld_byte = mem_q[7:0];
    endcase
    ld_half = alu_q[1] ? mem_q[31:16] : mem_q[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = mem_q;
    endcase
  end

  logic unused_ctrl;
  assign unused_ctrl = ^{ms_ctrl[4:2], ms_ctrl[0]};
`else
  assign load_data = mem_q;

  logic unused_ctrl;
  assign unused_ctrl = ^{ms_ctrl[4:2], ms_ctrl[0], ms_funct3};
`endif

  assign rf_we       = valid_q & reg_write_q & (rd_q != 5'd0);
  assign rf_waddr    = rd_q;
  assign rf_wdata    = mem_to_reg_q ? load_data : alu_q;
  assign wb_valid    = valid_q;
  assign wb_fwd_rd   = rf_we ? rd_q : 5'd0;
  assign wb_fwd_data = rf_wdata;
  assign wb_instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected WB outputs, one task per scenario.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ms_valid;
  logic [31:0] ms_mem_out, ms_alu_result;
  logic [4:0]  ms_rd;
  logic [5:0]  ms_ctrl;
  logic [2:0]  ms_funct3;
  logic        wb_stall, wb_flush;

  logic        rf_we, wb_valid;
  logic [4:0]  rf_waddr, wb_fwd_rd;
  logic [31:0] rf_wdata, wb_fwd_data;
  logic [63:0] wb_instret;

  logic        rf_we4, wb_valid4;
  logic [4:0]  rf_waddr4, wb_fwd_rd4;
  logic [31:0] rf_wdata4, wb_fwd_data4;
  logic [3:0]  wb_instret4;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ms_valid(ms_valid), .ms_mem_out(ms_mem_out),
    .ms_alu_result(ms_alu_result), .ms_rd(ms_rd), .ms_ctrl(ms_ctrl), .ms_funct3(ms_funct3),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_valid(wb_valid), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data), .wb_instret(wb_instret)
  );

  wb_stage #(.RET_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ms_valid(ms_valid), .ms_mem_out(ms_mem_out),
    .ms_alu_result(ms_alu_result), .ms_rd(ms_rd), .ms_ctrl(ms_ctrl), .ms_funct3(ms_funct3),
    .wb_stall(wb_stall), .wb_flush(wb_flush), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .wb_valid(wb_valid4), .wb_fwd_rd(wb_fwd_rd4),
    .wb_fwd_data(wb_fwd_data4), .wb_instret(wb_instret4)
  );

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;
    logic [3:0]  instret4;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model of the WB register contents.
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_mem;
  logic [2:0]  m_f3;
  logic [63:0] m_cnt;

  function automatic logic [31:0] model_load(input logic [31:0] mem, input logic [31:0] alu,
                                             input logic [2:0] f3);
`ifdef WB_LOAD_EXT_EN
    logic [31:0] sb_w, sh_w;
    sb_w = mem >> (alu[1:0] * 8);
    sh_w = mem >> (alu[1] * 16);
    case (f3)
      3'b000:  return {{24{sb_w[7]}}, sb_w[7:0]};
      3'b001:  return {{16{sh_w[15]}}, sh_w[15:0]};
      3'b100:  return {24'd0, sb_w[7:0]};
      3'b101:  return {16'd0, sh_w[15:0]};
      default: return mem;
    endcase
`else
    return mem + 32'd0 + {29'd0, f3 & 3'd0} + (alu & 32'd0);
`endif
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s = '{valid: wb_valid, we: rf_we, waddr: rf_waddr, wdata: rf_wdata, fwd_rd: wb_fwd_rd,
          fwd_data: wb_fwd_data, instret: wb_instret, instret4: wb_instret4};
    return s;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_mem = 0; m_f3 = 0; m_cnt = 0;
    sb.delete();
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next rising edge.
  task automatic drive(input logic v, input logic [5:0] c, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [2:0] f3,
                       input logic st, input logic fl);
    snap_t e;
    logic [31:0] wd;
    ms_valid = v; ms_ctrl = c; ms_rd = rd; ms_alu_result = alu; ms_mem_out = mem;
    ms_funct3 = f3; wb_stall = st; wb_flush = fl;
    if (!st) begin
      m_rd = rd; m_rw = c[5]; m_m2r = c[1]; m_alu = alu; m_mem = mem; m_f3 = f3;
    end
    if (fl) m_valid = 0;
    else if (!st) begin
      m_valid = v;
      if (v) m_cnt = m_cnt + 1;
    end
    wd = m_m2r ? model_load(m_mem, m_alu, m_f3) : m_alu;
    e.valid = m_valid;
    e.we = m_valid && m_rw && (m_rd != 0);
    e.waddr = m_rd;
    e.wdata = wd;
    e.fwd_rd = e.we ? m_rd : 5'd0;
    e.fwd_data = wd;
    e.instret = m_cnt;
    e.instret4 = m_cnt[3:0];
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    ms_valid = 0; ms_ctrl = 0; ms_rd = 0; ms_alu_result = 0; ms_mem_out = 0; ms_funct3 = 0;
    wb_stall = 0; wb_flush = 0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    snap_t o;
    rst_n = 0;
    ms_valid = 0; ms_ctrl = 0; ms_rd = 0; ms_alu_result = 0; ms_mem_out = 0; ms_funct3 = 0;
    wb_stall = 0; wb_flush = 0;
    model_clear();
    #3;
    o = observe();
    checks++;
    if (o !== '0) begin
      failures++; $display("FAIL reset_state act=%h exp=0", o);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_alu_write();
    snap_t e, o;
    drive(1, 6'b100000, 5'd5, 32'h1234, 32'hDEAD_BEEF, 3'b010, 0, 0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL alu_write act=%h exp=%h", o, e); end
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, wb_instret} !== {1'b1, 5'd5, 32'h1234, 64'd1}) begin
      failures++; $display("FAIL alu_write_const we=%b waddr=%0d wdata=%h instret=%0d exp 1/5/1234/1",
                           rf_we, rf_waddr, rf_wdata, wb_instret);
    end
  endtask

  task automatic test_x0_guard();
    snap_t e, o;
    drive(1, 6'b100000, 5'd0, 32'hFFFF, 32'h0, 3'b010, 0, 0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL x0_guard act=%h exp=%h", o, e); end
    checks++;
    if ({rf_we, wb_fwd_rd, wb_instret} !== {1'b0, 5'd0, 64'd2}) begin
      failures++; $display("FAIL x0_guard_const we=%b fwd_rd=%0d instret=%0d exp 0/0/2",
                           rf_we, wb_fwd_rd, wb_instret);
    end
    // Store: valid, no reg_write, still retires.
    drive(1, 6'b000100, 5'd9, 32'h40, 32'h0, 3'b010, 0, 0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL store_retire act=%h exp=%h", o, e); end
  endtask

  task automatic test_stall_flush();
    snap_t e, o;
    drive(1, 6'b100000, 5'd7, 32'hAA, 32'h0, 3'b010, 0, 0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL stall_setup act=%h exp=%h", o, e); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'b100010, 5'd11 + 5'(i), 32'h100 + i, 32'h55, 3'b000, 1, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL stall_hold%0d act=%h exp=%h", i, o, e); end
    end
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hAA}) begin
      failures++; $display("FAIL stall_frozen we=%b waddr=%0d wdata=%h exp 1/7/aa", rf_we, rf_waddr, rf_wdata);
    end
    drive(1, 6'b100000, 5'd12, 32'h777, 32'h0, 3'b010, 1, 1);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL stall_flush act=%h exp=%h", o, e); end
    checks++;
    if ({wb_valid, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b0, 5'd7, 32'hAA}) begin
      failures++; $display("FAIL stall_flush_const valid=%b we=%b waddr=%0d wdata=%h exp 0/0/7/aa",
                           wb_valid, rf_we, rf_waddr, rf_wdata);
    end
    drive(1, 6'b100000, 5'd9, 32'h55, 32'h0, 3'b010, 0, 1);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e) begin failures++; $display("FAIL flush_only act=%h exp=%h", o, e); end
  endtask

  task automatic test_load_ext();
    snap_t e, o;
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  offs [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
`ifdef WB_LOAD_EXT_EN
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
`else
    logic [31:0] want [4] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1, 6'b101010, 5'd3, {30'h400, offs[i]}, 32'h80FF7F01, f3s[i], 0, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL load%0d act=%h exp=%h", i, o, e); end
      checks++;
      if (rf_wdata !== want[i]) begin
        failures++; $display("FAIL load%0d_data act=%h exp=%h", i, rf_wdata, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 6'($urandom), 5'($urandom), $urandom, $urandom,
            3'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b%0d act=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    drive(1, 6'b100000, 5'd21, 32'hCAFE, 32'h0, 3'b010, 0, 0);
    @(posedge clk); #1;
    e = sb.pop_front(); o = observe();
    checks++;
    if (o !== e || rf_we !== 1'b1) begin failures++; $display("FAIL areset_setup act=%h exp=%h", o, e); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rf_we, wb_valid, wb_instret, rf_wdata} !== '0) begin
      failures++; $display("FAIL areset_clear we=%b valid=%b instret=%0d wdata=%h exp all 0",
                           rf_we, wb_valid, wb_instret, rf_wdata);
    end
    model_clear();
    ms_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_counter_wrap();
    snap_t e, o;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 6'b000000, 5'd1, i, 32'h0, 3'b010, 0, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin failures++; $display("FAIL wrap%0d act=%h exp=%h", i, o, e); end
    end
    checks++;
    if (wb_instret4 !== 4'd0 || wb_instret !== 64'd16) begin
      failures++; $display("FAIL wrap_final w4=%0d w64=%0d exp 0/16", wb_instret4, wb_instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_x0_guard();
    test_stall_flush();
    test_load_ext();
    test_back_to_back();
    test_async_reset();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
